// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: divides the fabric clock down to step ticks and
// runs one of four 8-LED patterns (scan/bounce, Johnson fill, blink, static).
// Software loads a new configuration through a valid/ready handshake.
module led_pattern_sequencer #(
    parameter int unsigned DIV_W       = 27,
    parameter int unsigned DEFAULT_DIV = 12500000
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [7:0]       cfg_pattern,
    input  logic             cfg_en,
    output logic [7:0]       led_out,
    output logic             busy,
    output logic             step_tick
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;
    typedef enum logic [1:0] {M_SCAN, M_FILL, M_BLINK, M_STATIC} mode_t;

    localparam logic [9:0] SCAN_INIT = 10'b0000000011;
    localparam logic [9:0] SCAN_TOP  = 10'b1100000000;

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [7:0]         pattern_q, pattern_d;
    logic               en_q, en_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               dir_q, dir_d;
    logic [9:0]         shadow_q, shadow_d;
    logic [7:0]         led_q, led_d;
    logic               busy_q, busy_d;
    logic               tick_q, tick_d;
    logic               ready_q, ready_d;

    logic               handshake;
    logic [9:0]         shifted;

    // Next-state logic: handshake capture, LOAD initialisation, prescaler and pattern steps
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        div_d     = div_q;
        pattern_d = pattern_q;
        en_d      = en_q;
        presc_d   = presc_q;
        dir_d     = dir_q;
        shadow_d  = shadow_q;
        led_d     = led_q;
        tick_d    = 1'b0;
        shifted   = '0;
        handshake = cfg_valid && ready_q;

        case (state_q)
            S_IDLE: begin
                presc_d = '0;
                if (handshake) begin
                    state_d   = S_LOAD;
                    mode_d    = mode_t'(cfg_mode);
                    div_d     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                    pattern_d = cfg_pattern;
                    en_d      = cfg_en;
                end
            end
            S_LOAD: begin
                presc_d  = '0;
                dir_d    = 1'b0;
                shadow_d = SCAN_INIT;
                if (en_q) begin
                    state_d = S_RUN;
                    case (mode_q)
                        M_SCAN:   led_d = SCAN_INIT[8:1];
                        M_STATIC: led_d = pattern_q;
                        default:  led_d = '0;
                    endcase
                end else begin
                    state_d = S_IDLE;
                    led_d   = '0;
                end
            end
            S_RUN: begin
                // A reload wins over a coinciding step so the LED value is frozen through LOAD
                if (handshake) begin
                    state_d   = S_LOAD;
                    presc_d   = '0;
                    mode_d    = mode_t'(cfg_mode);
                    div_d     = (cfg_div == '0) ? DIV_W'(1) : cfg_div;
                    pattern_d = cfg_pattern;
                    en_d      = cfg_en;
                end else if (presc_q == div_q - DIV_W'(1)) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                    case (mode_q)
                        M_SCAN: begin
                            shifted  = dir_q ? {1'b0, shadow_q[9:1]} : {shadow_q[8:0], 1'b0};
                            shadow_d = shifted;
                            led_d    = shifted[8:1];
                            if (shifted == SCAN_TOP) begin
                                dir_d = 1'b1;
                            end else if (shifted == SCAN_INIT) begin
                                dir_d = 1'b0;
                            end
                        end
                        M_FILL:   led_d = {led_q[6:0], ~led_q[7]};
                        M_BLINK:  led_d = ~led_q;
                        default:  led_d = pattern_q;
                    endcase
                end else begin
                    presc_d = presc_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                led_d   = '0;
            end
        endcase

        busy_d  = (state_d == S_RUN);
        ready_d = (state_d != S_LOAD);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            mode_q    <= M_SCAN;
            div_q     <= DIV_W'(DEFAULT_DIV);
            pattern_q <= '0;
            en_q      <= 1'b0;
            presc_q   <= '0;
            dir_q     <= 1'b0;
            shadow_q  <= SCAN_INIT;
            led_q     <= '0;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            div_q     <= div_d;
            pattern_q <= pattern_d;
            en_q      <= en_d;
            presc_q   <= presc_d;
            dir_q     <= dir_d;
            shadow_q  <= shadow_d;
            led_q     <= led_d;
            busy_q    <= busy_d;
            tick_q    <= tick_d;
            ready_q   <= ready_d;
        end
    end

    assign led_out   = led_q;
    assign busy      = busy_q;
    assign step_tick = tick_q;
    assign cfg_ready = ready_q;

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Run-time controller for the 8-LED front-panel scanner. It prescales the fabric clock into step ticks and sequences one of four LED patterns. The patterns are scan/bounce, Johnson fill, blink and static. Configuration comes from the PS-side register block over a valid/ready handshake. The block replaces the free-running shift-per-clock scanner so the pattern is visible and software-selectable.

Parameters:
DIV_W, 27, width of prescaler divider and counter
DEFAULT_DIV, 12500000, divider used after reset (125 MHz -> 10 steps/s)

Ports:
clk  input  1  fabric clock
aresetn  input  1  asynchronous active-low reset
cfg_valid  input  1  configuration word valid
cfg_ready  output  1  block can accept configuration
cfg_mode  input  2  0 SCAN, 1 FILL, 2 BLINK, 3 STATIC
cfg_div  input  DIV_W  clocks per step; 0 treated as 1
cfg_pattern  input  8  LED value for STATIC mode
cfg_en  input  1  1 run after load, 0 go idle
led_out  output  8  LED drive, registered
busy  output  1  high in RUN state
step_tick  output  1  one-cycle pulse when led_out advances

Behaviour:
- One clock; reset is asynchronous and active-low. Clock port clk, reset port aresetn.
- Reset values:
  - State IDLE, led_out=0, busy=0, step_tick=0, cfg_ready=1.
  - Latched mode=0, div=DEFAULT_DIV, pattern=0, prescaler=0, dir=0.
- FSM states: IDLE, LOAD, RUN.
  - A handshake occurs when cfg_valid && cfg_ready is high at a rising edge. It can occur in IDLE or RUN, and the next state is LOAD.
  - LOAD lasts exactly one cycle. During it cfg_ready=0, led_out holds its value, and the prescaler is held.
  - Config fields are captured at the handshake edge.
  - At the edge leaving LOAD: prescaler=0, dir=0, pattern registers set to the mode's initial value, step_tick=0.
  - Leaving LOAD, go to RUN if cfg_en=1. Otherwise go to IDLE with led_out=0.
  - cfg_ready=1 in IDLE and RUN, 0 only in LOAD.
- Prescaler (RUN only):
  - Counts 0..div-1 and wraps to 0.
  - When count==div-1 at an edge, the pattern advances at that edge and step_tick=1 for the following cycle.
  - With div=1, the pattern advances every cycle and step_tick stays high continuously.
  - The prescaler is held at 0 in IDLE and LOAD.
- SCAN (mode 0):
  - Internal 10-bit shadow, initial 10'b0000000011; led_out=shadow[8:1].
  - On each step: shift left if dir=0, right if dir=1.
  - After the shift, set dir=1 if shadow==10'b1100000000, and dir=0 if shadow==10'b0000000011.
  - Sequence: 01,03,06,0C,18,30,60,C0,80,C0,60,...,03,01; period 16 steps.
- FILL (mode 1): initial 00; each step led_out={led_out[6:0],~led_out[7]}; period 16.
- BLINK (mode 2): initial 00; each step led_out=~led_out.
- STATIC (mode 3): led_out=latched pattern from LOAD exit; step_tick still pulses, value constant.
- A reconfiguration mid-RUN always restarts the pattern from its initial value, including same-mode reloads.
- cfg_en=0 handshake from RUN: one LOAD cycle, then IDLE, led_out=0, busy=0.
- Asynchronous reset mid-RUN or mid-LOAD: all outputs go to reset values immediately. No pending configuration survives.
- The divider is DIV_W bits wide, so no width overflow is possible. cfg_div=0 is stored as 1.
- Implementation is 120-400 lines of RTL.

Test Plan:
- Reset: aresetn low 5 cycles, then high -> led_out=00, busy=0, cfg_ready=1, step_tick=0; stays idle 100 cycles.
- SCAN bounce: cfg mode=0, div=4, en=1 accepted at edge k -> LOAD cycle with cfg_ready=0; led_out=01 from k+1. Sequence 01,03,06,0C,18,30,60,C0,80,C0,60,30,18,0C,06,03,01, one step every 4 cycles. step_tick pulses 4 cycles apart.
- FILL/BLINK: mode=1, div=1 -> 00,01,03,07,0F,1F,3F,7F,FF,FE,FC,...,80,00, one value per cycle. Mode=2, div=2 -> 00,FF,00,FF every 2 cycles.
- Mid-run reload: SCAN div=3 at led_out=30, then mode=3, pattern=A5 -> led_out holds 30 during LOAD, then A5 constant. step_tick every 3 cycles.
- Stop and div=0: en=0 handshake -> IDLE, led_out=00, busy=0. Then mode=2, div=0, en=1 -> toggles every cycle, step_tick continuously high.
- Async reset: assert aresetn low mid-clock during RUN -> led_out=00 and busy=0 without a clock edge. After release, state is IDLE.
